// File: rtl/lrd_sched_pkg.sv
// Shared types and constants for the leaky-ReLU-derivative row scheduler.
package lrd_sched_pkg;

    localparam int DATA_W       = 16;  // Q8.8 element width
    localparam int FRAC_W       = 8;   // fractional bits of the leak factor
    localparam int RD_LATENCY   = 1;   // request -> buffer data, in cycles
    localparam int LANE_LATENCY = 1;   // buffer data -> lane result, in cycles

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/leaky_relu_derivative_child.sv
// One derivative lane: passes non-negative data, scales negative data by the
// Q8.8 leak factor, and registers the result together with its valid flag.
module leaky_relu_derivative_child
    import lrd_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic signed [DATA_W-1:0] leak_in,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] data_out
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [DATA_W-1:0]   result;
    logic                       unused_product_bits;

    // Full-width signed product; taking bits [FRAC_W +: DATA_W] is the
    // arithmetic shift by FRAC_W followed by truncation (no saturation).
    assign product = (2*DATA_W)'(data_in) * (2*DATA_W)'(leak_in);
    assign result  = data_in[DATA_W-1] ? product[FRAC_W +: DATA_W] : data_in;

    // Bits outside the Q8.8 window are intentionally dropped.
    assign unused_product_bits = ^{product[2*DATA_W-1:FRAC_W+DATA_W], product[FRAC_W-1:0]};

    // Lane output register; an invalid beat always presents zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in;
            data_out  <= valid_in ? result : '0;
        end
    end

endmodule

// File: rtl/leaky_relu_derivative_scheduler.sv
// Fetches a block of rows from the unified buffer and feeds them through
// NUM_LANES derivative lanes, skewing lane i by i cycles so results line up
// diagonally with the systolic array columns.
module leaky_relu_derivative_scheduler
    import lrd_sched_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int ROW_W     = 8
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_in,
    input  logic [ROW_W-1:0]            num_rows_in,
    input  logic [ROW_W-1:0]            base_addr_in,
    input  logic signed [DATA_W-1:0]    leak_factor_in,
    input  logic                        stall_in,
    output logic                        ub_rd_req_out,
    output logic [ROW_W-1:0]            ub_rd_addr_out,
    input  logic                        ub_rd_valid_in,
    input  logic [NUM_LANES*DATA_W-1:0] ub_rd_data_in,
    output logic [NUM_LANES-1:0]        lane_valid_out,
    output logic [NUM_LANES*DATA_W-1:0] lane_data_out,
    output logic                        busy_out,
    output logic                        done_out
);

    // Cycles from the last request until the last lane result is out.
    localparam int DRAIN_LOAD = NUM_LANES - 1 + RD_LATENCY + LANE_LATENCY;
    localparam int DRAIN_W    = $clog2(DRAIN_LOAD + 1);

    state_t                   state_q, state_d;
    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [DRAIN_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0]         num_rows_q, num_rows_d;
    logic [ROW_W-1:0]         base_q, base_d;
    logic signed [DATA_W-1:0] leak_q, leak_d;

    // Control state and operation parameters latched at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            num_rows_q  <= '0;
            base_q      <= '0;
            leak_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values produced by the combinational block.
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            num_rows_q  <= num_rows_d;
            base_q      <= base_d;
            leak_q      <= leak_d;
        end
    end

    // Next-state logic, read issue and status outputs.
    always_comb begin
        // NOTE: every signal written below gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        num_rows_d    = num_rows_q;
        base_d        = base_q;
        leak_d        = leak_q;
        ub_rd_req_out = 1'b0;
        busy_out      = 1'b1;
        done_out      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    num_rows_d = num_rows_in;
                    base_d     = base_addr_in;
                    leak_d     = leak_factor_in;
                    row_cnt_d  = '0;
                    state_d    = (num_rows_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!stall_in) begin
                    ub_rd_req_out = 1'b1;
                    row_cnt_d     = row_cnt_q + ROW_W'(1);
                    if (row_cnt_q == num_rows_q - ROW_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_W'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                // Drain runs on a fixed count; stall only gates new reads.
                drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row address wraps modulo 2^ROW_W by construction.
    assign ub_rd_addr_out = base_q + row_cnt_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic                     lane_v;
        logic signed [DATA_W-1:0] lane_d;

        if (g == 0) begin : g_direct
            assign lane_v = ub_rd_valid_in;
            assign lane_d = ub_rd_data_in[0 +: DATA_W];
        end else begin : g_skew
            logic [g-1:0]             skew_v;
            logic [g-1:0][DATA_W-1:0] skew_d;

            // g-stage skew line carrying valid and data for this lane.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    // NOTE: the skew stages are reset, unlike a RAM array, so
                    // a reset discards in-flight rows and no stale valid leaks out.
                    skew_v <= '0;
                    skew_d <= '0;
                end else begin
                    skew_v[0] <= ub_rd_valid_in;
                    skew_d[0] <= ub_rd_data_in[g*DATA_W +: DATA_W];
                    for (int s = 1; s < g; s++) begin
                        skew_v[s] <= skew_v[s-1];
                        skew_d[s] <= skew_d[s-1];
                    end
                end
            end

            assign lane_v = skew_v[g-1];
            assign lane_d = skew_d[g-1];
        end

        leaky_relu_derivative_child u_child (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (lane_v),
            .data_in   (lane_d),
            .leak_in   (leak_q),
            .valid_out (lane_valid_out[g]),
            .data_out  (lane_data_out[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_leaky_relu_derivative_scheduler.sv
// Self-checking bench: a behavioural buffer model answers reads, a monitor
// records requests/results/done per cycle, and a reference model derives the
// expected event schedule from the operation parameters and stall pattern.
module tb_leaky_relu_derivative_scheduler;

    localparam int NUM_LANES = 2;
    localparam int ROW_W     = 8;
    localparam int DW        = 16;

    logic                    clk;
    logic                    rst;
    logic                    start_in;
    logic [ROW_W-1:0]        num_rows_in;
    logic [ROW_W-1:0]        base_addr_in;
    logic [DW-1:0]           leak_factor_in;
    logic                    stall_in;
    logic                    ub_rd_req_out;
    logic [ROW_W-1:0]        ub_rd_addr_out;
    logic                    ub_rd_valid_in;
    logic [NUM_LANES*DW-1:0] ub_rd_data_in;
    logic [NUM_LANES-1:0]    lane_valid_out;
    logic [NUM_LANES*DW-1:0] lane_data_out;
    logic                    busy_out;
    logic                    done_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NUM_LANES*DW-1:0] mem [256];
    logic                    pend_v = 1'b0;
    logic [NUM_LANES*DW-1:0] pend_d = '0;
    logic                    rec    = 1'b0;

    int            got_req[$];
    int            exp_req[$];
    int            got_done[$];
    int            exp_done[$];
    logic [DW-1:0] got_lane[int];
    logic [DW-1:0] exp_lane[int];
    int            idle_nonzero = 0;

    leaky_relu_derivative_scheduler #(.NUM_LANES(NUM_LANES), .ROW_W(ROW_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .num_rows_in    (num_rows_in),
        .base_addr_in   (base_addr_in),
        .leak_factor_in (leak_factor_in),
        .stall_in       (stall_in),
        .ub_rd_req_out  (ub_rd_req_out),
        .ub_rd_addr_out (ub_rd_addr_out),
        .ub_rd_valid_in (ub_rd_valid_in),
        .ub_rd_data_in  (ub_rd_data_in),
        .lane_valid_out (lane_valid_out),
        .lane_data_out  (lane_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer model: data for a request seen in cycle t is presented in t+1.
    initial begin
        ub_rd_valid_in = 1'b0;
        ub_rd_data_in  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ub_rd_valid_in = pend_v;
            ub_rd_data_in  = pend_d;
        end
    end

    // Mid-cycle monitor.
    always @(negedge clk) begin
        pend_v = ub_rd_req_out;
        pend_d = mem[ub_rd_addr_out];
        if (rec) begin
            if (ub_rd_req_out) got_req.push_back(cyc * 256 + int'(ub_rd_addr_out));
            if (done_out) got_done.push_back(cyc);
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_valid_out[i]) got_lane[cyc*NUM_LANES+i] = lane_data_out[i*DW +: DW];
                else if (lane_data_out[i*DW +: DW] != '0) idle_nonzero++;
            end
        end
    end

    // Leaky-ReLU derivative lane rule in plain integer arithmetic.
    function automatic logic [DW-1:0] ref_deriv(input logic [DW-1:0] d, input logic [DW-1:0] leak);
        int dv, lv, p;
        dv = int'($signed(d));
        lv = int'($signed(leak));
        if (dv >= 0) return d;
        p = dv * lv;
        p = p >>> 8;
        return p[DW-1:0];
    endfunction

    // Expected schedule of one operation started (start sampled) at the end of cycle s.
    task automatic model_op(input int s, input int n, input int base, input logic [DW-1:0] leak,
                            input logic [63:0] stall_mask, output int done_cyc);
        int c, k, last, rel, addr;
        c = s + 1;
        k = 0;
        last = s;
        while (k < n) begin
            rel = c - s - 1;
            if (!(rel < 64 && stall_mask[rel] === 1'b1)) begin
                addr = (base + k) % 256;
                exp_req.push_back(c * 256 + addr);
                for (int i = 0; i < NUM_LANES; i++)
                    exp_lane[(c+2+i)*NUM_LANES+i] = ref_deriv(mem[addr][i*DW +: DW], leak);
                last = c;
                k++;
            end
            c++;
        end
        done_cyc = (n == 0) ? s + 1 : last + NUM_LANES + 2;
        exp_done.push_back(done_cyc);
    endtask

    task automatic clear_sb();
        got_req.delete();  exp_req.delete();
        got_done.delete(); exp_done.delete();
        got_lane.delete(); exp_lane.delete();
        idle_nonzero = 0;
    endtask

    // Drives one operation; other inputs carry random junk outside the start cycle.
    task automatic drive_op(input int n, input int base, input logic [DW-1:0] leak,
                            input logic [63:0] stall_mask, input int pulse_k,
                            input logic [DW-1:0] pulse_leak, output int s);
        int post;
        post = -1;
        @(posedge clk); #1;
        s = cyc;
        start_in       = 1'b1;
        num_rows_in    = ROW_W'(n);
        base_addr_in   = ROW_W'(base);
        leak_factor_in = leak;
        stall_in       = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start_in       = (k == pulse_k);
            num_rows_in    = ROW_W'($urandom);
            base_addr_in   = ROW_W'($urandom);
            leak_factor_in = (k == pulse_k) ? pulse_leak : DW'($urandom);
            stall_in       = (k < 64) ? stall_mask[k] : 1'b0;
            if (post < 0 && got_done.size() > 0) post = NUM_LANES + 6;
            if (post == 0) break;
            if (post > 0) post--;
        end
        start_in = 1'b0;
        stall_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b0; stall_in = 1'b0;
        num_rows_in = '0; base_addr_in = '0; leak_factor_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ub_rd_req_out, ub_rd_addr_out, lane_valid_out, lane_data_out, busy_out, done_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b addr=%h valid=%b data=%h busy=%b done=%b, want all zero",
                     ub_rd_req_out, ub_rd_addr_out, lane_valid_out, lane_data_out, busy_out, done_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy_out, ub_rd_req_out, done_out, lane_valid_out} !== '0) begin
            bad++;
            $display("FAIL post_reset_idle: got busy=%b req=%b done=%b valid=%b, want all zero",
                     busy_out, ub_rd_req_out, done_out, lane_valid_out);
        end
    endtask

    // Worked example with hand-derived constants.
    task automatic test_basic();
        int s, key0, key1;
        for (int a = 8'h10; a <= 8'h12; a++) mem[a] = 32'hFE00_0300;
        clear_sb();
        rec = 1'b1;
        drive_op(3, 8'h10, 16'h0080, 64'h0, -1, 16'h0, s);
        rec = 1'b0;
        total++;
        if (got_req.size() != 3) begin
            bad++;
            $display("FAIL basic_req_count: got %0d, want 3", got_req.size());
        end
        for (int k = 0; k < 3; k++) begin
            int want;
            want = (s + 1 + k) * 256 + 8'h10 + k;
            total++;
            if (k >= got_req.size() || got_req[k] != want) begin
                bad++;
                $display("FAIL basic_req[%0d]: got %0d, want cycle+%0d addr=%02h",
                         k, (k < got_req.size()) ? got_req[k] - s * 256 : -1, 1 + k, 8'h10 + k);
            end
        end
        key0 = (s + 3) * NUM_LANES + 0;
        key1 = (s + 4) * NUM_LANES + 1;
        total++;
        if (!got_lane.exists(key0) || got_lane[key0] !== 16'h0300) begin
            bad++;
            $display("FAIL basic_lane0: got %h, want 0300 at cycle+3",
                     got_lane.exists(key0) ? got_lane[key0] : 16'hxxxx);
        end
        total++;
        if (!got_lane.exists(key1) || got_lane[key1] !== 16'hFF00) begin
            bad++;
            $display("FAIL basic_lane1: got %h, want ff00 at cycle+4",
                     got_lane.exists(key1) ? got_lane[key1] : 16'hxxxx);
        end
        total++;
        if (got_lane.num() != 6) begin
            bad++;
            $display("FAIL basic_lane_count: got %0d, want 6", got_lane.num());
        end
        total++;
        if (got_done.size() != 1 || got_done[0] != s + 7) begin
            bad++;
            $display("FAIL basic_done: got count=%0d at cycle+%0d, want one at cycle+7",
                     got_done.size(), (got_done.size() > 0) ? got_done[0] - s : -1);
        end
    endtask

    // One operation checked against the reference model.
    task automatic test_operation(input string name, input int n, input int base, input logic [DW-1:0] leak,
                                  input logic [63:0] stall_mask, input int pulse_k, input logic [DW-1:0] pulse_leak);
        int s, d;
        clear_sb();
        rec = 1'b1;
        drive_op(n, base, leak, stall_mask, pulse_k, pulse_leak, s);
        rec = 1'b0;
        model_op(s, n, base, leak, stall_mask, d);
        total++;
        if (got_done.size() != 1 || got_done[0] != d) begin
            bad++;
            $display("FAIL %s done: got count=%0d first at cycle+%0d, want one at cycle+%0d",
                     name, got_done.size(), (got_done.size() > 0) ? got_done[0] - s : -1, d - s);
        end
        total++;
        if (got_req.size() != exp_req.size()) begin
            bad++;
            $display("FAIL %s req_count: got %0d, want %0d", name, got_req.size(), exp_req.size());
        end
        foreach (exp_req[k]) begin
            int gv;
            gv = (k < got_req.size()) ? got_req[k] : -256;
            total++;
            if (gv != exp_req[k]) begin
                bad++;
                $display("FAIL %s req[%0d]: got cycle+%0d addr=%02h, want cycle+%0d addr=%02h", name, k,
                         gv / 256 - s, gv % 256, exp_req[k] / 256 - s, exp_req[k] % 256);
            end
        end
        total++;
        if (got_lane.num() != exp_lane.num()) begin
            bad++;
            $display("FAIL %s lane_count: got %0d, want %0d", name, got_lane.num(), exp_lane.num());
        end
        foreach (exp_lane[key]) begin
            total++;
            if (!got_lane.exists(key) || got_lane[key] !== exp_lane[key]) begin
                bad++;
                $display("FAIL %s lane%0d at cycle+%0d: got %h, want %h", name, key % NUM_LANES,
                         key / NUM_LANES - s, got_lane.exists(key) ? got_lane[key] : 16'hxxxx, exp_lane[key]);
            end
        end
        total++;
        if (idle_nonzero != 0) begin
            bad++;
            $display("FAIL %s invalid_lane_data: got %0d nonzero beats, want 0", name, idle_nonzero);
        end
    endtask

    task automatic test_reset_mid_issue();
        clear_sb();
        @(posedge clk); #1;
        start_in = 1'b1; num_rows_in = 8'd20; base_addr_in = 8'h40; leak_factor_in = 16'h0080; stall_in = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({ub_rd_req_out, ub_rd_addr_out, lane_valid_out, lane_data_out, busy_out, done_out} !== '0) begin
            bad++;
            $display("FAIL midreset_async: got req=%b addr=%h valid=%b data=%h busy=%b done=%b, want all zero",
                     ub_rd_req_out, ub_rd_addr_out, lane_valid_out, lane_data_out, busy_out, done_out);
        end
        rec = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 rec = 1'b0;
        total++;
        if (got_req.size() != 0 || got_lane.num() != 0 || got_done.size() != 0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset_stale: got reqs=%0d valids=%0d dones=%0d busy=%b, want 0 0 0 0",
                     got_req.size(), got_lane.num(), got_done.size(), busy_out);
        end
    endtask

    // start_in held high through DONE: the next operation begins on the first IDLE cycle.
    task automatic test_back_to_back();
        int s, s2, da, db, post;
        clear_sb();
        rec = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start_in = 1'b1; num_rows_in = 8'd2; base_addr_in = 8'h20; leak_factor_in = 16'h0040; stall_in = 1'b0;
        model_op(s, 2, 8'h20, 16'h0040, 64'h0, da);
        s2 = da + 1;
        model_op(s2, 3, 8'h80, 16'h00C0, 64'h0, db);
        post = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            num_rows_in = 8'd3; base_addr_in = 8'h80; leak_factor_in = 16'h00C0;
            start_in = (cyc <= s2);
            if (post < 0 && got_done.size() > 1) post = 8;
            if (post == 0) break;
            if (post > 0) post--;
        end
        start_in = 1'b0;
        rec = 1'b0;
        foreach (exp_done[k]) begin
            total++;
            if (k >= got_done.size() || got_done[k] != exp_done[k]) begin
                bad++;
                $display("FAIL b2b done[%0d]: got cycle+%0d, want cycle+%0d", k,
                         (k < got_done.size()) ? got_done[k] - s : -1, exp_done[k] - s);
            end
        end
        total++;
        if (got_req.size() != exp_req.size() || got_done.size() != 2) begin
            bad++;
            $display("FAIL b2b counts: got reqs=%0d dones=%0d, want reqs=%0d dones=2",
                     got_req.size(), got_done.size(), exp_req.size());
        end
        foreach (exp_req[k]) begin
            int gv;
            gv = (k < got_req.size()) ? got_req[k] : -256;
            total++;
            if (gv != exp_req[k]) begin
                bad++;
                $display("FAIL b2b req[%0d]: got cycle+%0d addr=%02h, want cycle+%0d addr=%02h", k,
                         gv / 256 - s, gv % 256, exp_req[k] / 256 - s, exp_req[k] % 256);
            end
        end
        foreach (exp_lane[key]) begin
            total++;
            if (!got_lane.exists(key) || got_lane[key] !== exp_lane[key]) begin
                bad++;
                $display("FAIL b2b lane%0d at cycle+%0d: got %h, want %h", key % NUM_LANES,
                         key / NUM_LANES - s, got_lane.exists(key) ? got_lane[key] : 16'hxxxx, exp_lane[key]);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++)
            for (int i = 0; i < NUM_LANES; i++) mem[a][i*DW +: DW] = DW'($urandom);

        test_reset();
        test_basic();
        test_operation("stall_gap",     3, 8'h10, 16'h0080, 64'h6, -1, 16'h0);
        test_operation("zero_rows",     0, 8'h33, 16'h0080, 64'h0, -1, 16'h0);
        test_operation("addr_wrap",     3, 8'hFE, 16'h0100, 64'h0, -1, 16'h0);
        test_operation("start_ignored", 6, 8'h50, 16'h0040, 64'h0,  2, 16'h0200);
        test_reset_mid_issue();
        test_operation("after_reset",   4, 8'h60, 16'h0080, 64'h0, -1, 16'h0);
        test_back_to_back();
        for (int r = 0; r < 12; r++) begin
            logic [63:0] mask;
            mask = {$urandom, $urandom} & {$urandom, $urandom};
            test_operation("random", int'($urandom_range(0, 10)), int'($urandom_range(0, 255)),
                           DW'($urandom), mask, -1, 16'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
